ra_2r1w_fwd: RTL and testbench
==============================

# ra_2r1w_fwd

Parametrised 2-read/1-write register-file array wrapper, the successor to the fixed 64x72 SDR wrapper. It generalises depth, width and read-data latching, and adds four behaviours: segment write masks, same-cycle write-to-read forwarding, per-port read-valid outputs, and a hardware zero-initialisation sweep after reset. It sits between core register-file control logic and the storage, presenting registered inputs and valid-qualified read data.

## Interface
- DEPTH, 64: number of entries; power of two, 16..256. AW = log2(DEPTH).
- WIDTH, 72: bits per entry.
- SEGW, 24: write-mask granularity; WIDTH % SEGW == 0. NSEG = WIDTH/SEGW.
- LATCHRD, 1: 1 = read data registered; 0 = read data combinational from the array.
- BYPASS, 1: 1 = same-cycle write-to-read forwarding; 0 = reads return pre-write contents.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- busy  out  1  high during reset and the init sweep; port requests are ignored while high.
- rd_enb_0 / rd_enb_1  in  1  read-port enables.
- rd_adr_0 / rd_adr_1  in  [0:AW-1]  read addresses.
- rd_val_0 / rd_val_1  out  1  rd_dat_n is valid.
- rd_dat_0 / rd_dat_1  out  [0:WIDTH-1]  read data; forced to zero whenever rd_val_n = 0.
- wr_enb_0  in  1  write enable.
- wr_adr_0  in  [0:AW-1]  write address.
- wr_msk_0  in  [0:NSEG-1]  segment mask; bit i covers wr_dat_0[i*SEGW : i*SEGW+SEGW-1].
- wr_dat_0  in  [0:WIDTH-1]  write data.

## Operation
- Input stage: all enables, addresses, masks and write data are registered every edge. Registered enable = enb & ~busy, so enables presented while busy are dropped. On reset, all input registers clear to 0.
- Storage: a behavioural array of DEPTH x WIDTH. It is written on the rising edge at the end of the access cycle. Only segments whose registered mask bit is 1 are updated. A mask of all zeros is a no-op write.
- Read: the registered address indexes the array during the access cycle.
- Forwarding (BYPASS=1): if wr_enb_q and rd_enb_n_q are both set and the addresses match, read data is a per-segment merge. Segments with the mask bit set take wr_dat_q; the others take the old contents. With BYPASS=0, read data is the old contents.
- Both read ports may target the same address, including the write address; each resolves independently.
- Init FSM, two states, INIT and READY:
  - reset forces INIT with cnt = 0.
  - In INIT with reset low, each edge does mem[cnt] <= 0 and cnt <= cnt+1.
  - On the edge where cnt == DEPTH-1, the FSM moves to READY.
  - READY holds until the next reset.
  - busy = (state == INIT), so busy is also high while reset is asserted.
- Reset mid-operation: the sweep restarts from entry 0. In-flight reads are discarded (rd_val cleared) and registered write requests are discarded. Array contents are rewritten to zero by the sweep.
- Reset values: busy = 1, rd_val_0 = rd_val_1 = 0, rd_dat_0 = rd_dat_1 = 0, cnt = 0.

## Timing
- Cycle numbering: C0 is the cycle in which inputs are presented. Edge E1 registers them. C1 is the access cycle. Edge E2 performs the write.
- LATCHRD=1: rd_dat_n and rd_val_n are registered at E2 and valid in C2, a latency of 2 edges.
- LATCHRD=0: rd_val_n is the registered enable; data is valid combinationally in C1, a latency of 1 edge.
- Write visibility: a write in C0 is visible to a read presented in C1 or later. A read presented in C0 to the same address sees the new data only when BYPASS=1.
- Init duration: busy falls after exactly DEPTH edges following the first edge sampled with reset low. The first accepted request is one presented in the first cycle with busy = 0.
- Throughput: one write and two reads every cycle, with no back-pressure outside busy.

## Test plan
- Init sweep, DEPTH=64: pre-load garbage via backdoor, then pulse reset for 2 cycles. Required: busy high for exactly 64 edges after reset falls; afterwards, reads of addresses 0, 31 and 63 return 0 with rd_val set.
- Latency, LATCHRD=1: write 0x123456789ABCDEF012 to address 5, then read address 5 on port 0 the next cycle. Required: rd_val_0 and data appear 2 edges after the read is presented; rd_dat_0 = 0 on every cycle where rd_val_0 is low.
- Forwarding: with entry 9 = all-ones, write 0 to address 9 with wr_msk_0 = 3'b010, and read address 9 on both ports in the same cycle.
  - BYPASS=1: both ports return 0xFFFFFF_000000_FFFFFF.
  - BYPASS=0: both ports return all-ones.
  - Either mode: a subsequent read returns 0xFFFFFF_000000_FFFFFF.
- Mask merge: write 0xAA..AA to address 3 with mask 111, then 0x55..55 with mask 101. Required: read returns 0x555555_AAAAAA_555555.
- Busy drop: assert rd_enb_0 and wr_enb_0 during the sweep. Required: rd_val_0 never asserts, and the target entry reads 0 after the sweep.
- Reset mid-sweep and mid-read: assert reset with cnt = 20 and a read in flight. Required: rd_val clears the next cycle, the sweep restarts, and busy lasts a full DEPTH edges.

Source files
------------

// File: rtl/ra_2r1w_fwd.sv
// 2-read/1-write register-file wrapper: registered inputs, segment write masks,
// optional write-to-read forwarding, optional read latching and zero-init sweep.
module ra_2r1w_fwd #(
    parameter int DEPTH   = 64,
    parameter int WIDTH   = 72,
    parameter int SEGW    = 24,
    parameter int LATCHRD = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int NSEG   = WIDTH / SEGW
) (
    input  logic             clk,
    input  logic             reset,
    output logic             busy,
    input  logic             rd_enb_0,
    input  logic [0:AW-1]    rd_adr_0,
    output logic             rd_val_0,
    output logic [0:WIDTH-1] rd_dat_0,
    input  logic             rd_enb_1,
    input  logic [0:AW-1]    rd_adr_1,
    output logic             rd_val_1,
    output logic [0:WIDTH-1] rd_dat_1,
    input  logic             wr_enb_0,
    input  logic [0:AW-1]    wr_adr_0,
    input  logic [0:NSEG-1]  wr_msk_0,
    input  logic [0:WIDTH-1] wr_dat_0
);

    typedef enum logic {INIT, READY} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   cnt, cnt_nx;

    logic            rd_enb_q [2];
    logic [AW-1:0]   rd_adr_q [2];
    logic            wr_enb_q;
    logic [AW-1:0]   wr_adr_q;
    logic [0:NSEG-1] wr_msk_q;
    logic [0:WIDTH-1] wr_dat_q;

    logic [0:WIDTH-1] mem [DEPTH];
    logic [0:WIDTH-1] rd_mux [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b0;
        case (state)
            INIT: begin
                busy   = 1'b1;
                cnt_nx = cnt + AW'(1);
                if (cnt == AW'(DEPTH - 1))
                    state_nx = READY;
            end
            READY: busy = 1'b0;
        endcase
    end

    // Enables are masked with busy so requests made during the sweep never issue
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_enb_q[0] <= 1'b0;
            rd_enb_q[1] <= 1'b0;
            rd_adr_q[0] <= '0;
            rd_adr_q[1] <= '0;
            wr_enb_q    <= 1'b0;
            wr_adr_q    <= '0;
            wr_msk_q    <= '0;
            wr_dat_q    <= '0;
        end else begin
            rd_enb_q[0] <= rd_enb_0 & ~busy;
            rd_enb_q[1] <= rd_enb_1 & ~busy;
            rd_adr_q[0] <= rd_adr_0;
            rd_adr_q[1] <= rd_adr_1;
            wr_enb_q    <= wr_enb_0 & ~busy;
            wr_adr_q    <= wr_adr_0;
            wr_msk_q    <= wr_msk_0;
            wr_dat_q    <= wr_dat_0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
            end else if (wr_enb_q) begin
                for (int unsigned i = 0; i < NSEG; i++)
                    if (wr_msk_q[i])
                        mem[wr_adr_q][i*SEGW +: SEGW] <= wr_dat_q[i*SEGW +: SEGW];
            end
        end
    end

    // Forwarded segments override the array word; idle ports read as zero
    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            rd_mux[n] = mem[rd_adr_q[n]];
            if (BYPASS != 0 && wr_enb_q && rd_enb_q[n] && rd_adr_q[n] == wr_adr_q) begin
                for (int unsigned i = 0; i < NSEG; i++)
                    if (wr_msk_q[i])
                        rd_mux[n][i*SEGW +: SEGW] = wr_dat_q[i*SEGW +: SEGW];
            end
            if (!rd_enb_q[n])
                rd_mux[n] = '0;
        end
    end

    if (LATCHRD != 0) begin : g_lat
        logic             val_r [2];
        logic [0:WIDTH-1] dat_r [2];

        always_ff @(posedge clk) begin
            if (reset) begin
                val_r[0] <= 1'b0;
                val_r[1] <= 1'b0;
                dat_r[0] <= '0;
                dat_r[1] <= '0;
            end else begin
                val_r[0] <= rd_enb_q[0];
                val_r[1] <= rd_enb_q[1];
                dat_r[0] <= rd_mux[0];
                dat_r[1] <= rd_mux[1];
            end
        end

        assign rd_val_0 = val_r[0];
        assign rd_val_1 = val_r[1];
        assign rd_dat_0 = dat_r[0];
        assign rd_dat_1 = dat_r[1];
    end else begin : g_comb
        assign rd_val_0 = rd_enb_q[0];
        assign rd_val_1 = rd_enb_q[1];
        assign rd_dat_0 = rd_mux[0];
        assign rd_dat_1 = rd_mux[1];
    end

endmodule

// File: tb/tb_ra_2r1w_fwd.sv
// Bench for ra_2r1w_fwd: a latched/forwarding instance and a combinational/
// non-forwarding instance share stimulus and are checked against one array model.
module tb_ra_2r1w_fwd;

    localparam int DEPTH = 64;
    localparam int WIDTH = 72;
    localparam int SEGW  = 24;
    localparam int NSEG  = 3;
    localparam int AW    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             rd_enb_0, rd_enb_1, wr_enb_0;
    logic [AW-1:0]    rd_adr_0, rd_adr_1, wr_adr_0;
    logic [NSEG-1:0]  wr_msk_0;
    logic [WIDTH-1:0] wr_dat_0;

    logic             busy_a, busy_b, val_a0, val_a1, val_b0, val_b1;
    logic [WIDTH-1:0] dat_a0, dat_a1, dat_b0, dat_b1;

    int n_cmp = 0;
    int n_bad = 0;

    ra_2r1w_fwd #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEGW(SEGW), .LATCHRD(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .busy(busy_a),
        .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0), .rd_val_0(val_a0), .rd_dat_0(dat_a0),
        .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1), .rd_val_1(val_a1), .rd_dat_1(dat_a1),
        .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_msk_0(wr_msk_0), .wr_dat_0(wr_dat_0)
    );

    ra_2r1w_fwd #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEGW(SEGW), .LATCHRD(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .busy(busy_b),
        .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0), .rd_val_0(val_b0), .rd_dat_0(dat_b0),
        .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1), .rd_val_1(val_b1), .rd_dat_1(dat_b1),
        .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_msk_0(wr_msk_0), .wr_dat_0(wr_dat_0)
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Mask bit for segment 0 (most significant) is the mask MSB
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old, input logic [WIDTH-1:0] nw,
                                               input logic [NSEG-1:0] msk);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NSEG; i++)
            if (msk[NSEG-1-i]) m[WIDTH-1-i*SEGW -: SEGW] = '1;
        return (old & ~m) | (nw & m);
    endfunction

    // Model: array cleared by reset, busy for DEPTH clean edges, accepted requests
    // resolve one edge later against the array plus the same-cycle write.
    bit               model_on = 1'b0;
    int               busy_cnt = 0;
    logic [WIDTH-1:0] mdl_mem [DEPTH];
    bit               pw_en, accept;
    logic [AW-1:0]    pw_adr;
    logic [NSEG-1:0]  pw_msk;
    logic [WIDTH-1:0] pw_dat, old;
    logic [1:0]       ren, cur_val, lat_val;
    logic [AW-1:0]    radr [2];
    logic [WIDTH-1:0] cur_byp [2];
    logic [WIDTH-1:0] cur_nob [2];
    logic [WIDTH-1:0] lat_dat [2];

    always @(posedge clk) begin
        if (reset) begin
            model_on = 1'b1;
            busy_cnt = DEPTH;
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
            pw_en   = 1'b0;
            cur_val = '0;
            lat_val = '0;
            for (int n = 0; n < 2; n++) begin
                cur_byp[n] = '0;
                cur_nob[n] = '0;
                lat_dat[n] = '0;
            end
        end else if (model_on) begin
            if (pw_en) mdl_mem[pw_adr] = merge(mdl_mem[pw_adr], pw_dat, pw_msk);
            lat_val = cur_val;
            lat_dat[0] = cur_byp[0];
            lat_dat[1] = cur_byp[1];
            accept = (busy_cnt == 0);
            pw_en  = accept && wr_enb_0;
            pw_adr = wr_adr_0;
            pw_msk = wr_msk_0;
            pw_dat = wr_dat_0;
            ren     = {rd_enb_1, rd_enb_0};
            radr[0] = rd_adr_0;
            radr[1] = rd_adr_1;
            for (int n = 0; n < 2; n++) begin
                cur_val[n] = accept && ren[n];
                old        = mdl_mem[radr[n]];
                cur_nob[n] = cur_val[n] ? old : '0;
                cur_byp[n] = !cur_val[n] ? '0 :
                             (pw_en && radr[n] == pw_adr) ? merge(old, pw_dat, pw_msk) : old;
            end
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy_a", WIDTH'(busy_a), WIDTH'(busy_cnt != 0));
            chk("busy_b", WIDTH'(busy_b), WIDTH'(busy_cnt != 0));
            chk("val_a0", WIDTH'(val_a0), WIDTH'(lat_val[0]));
            chk("val_a1", WIDTH'(val_a1), WIDTH'(lat_val[1]));
            chk("dat_a0", dat_a0, lat_dat[0]);
            chk("dat_a1", dat_a1, lat_dat[1]);
            chk("val_b0", WIDTH'(val_b0), WIDTH'(cur_val[0]));
            chk("val_b1", WIDTH'(val_b1), WIDTH'(cur_val[1]));
            chk("dat_b0", dat_b0, cur_nob[0]);
            chk("dat_b1", dat_b1, cur_nob[1]);
        end
    end

    task automatic idle();
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;
        wr_enb_0 = 1'b0;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [NSEG-1:0] m, input logic [WIDTH-1:0] d);
        wr_enb_0 = 1'b1; wr_adr_0 = a; wr_msk_0 = m; wr_dat_0 = d;
        @(negedge clk);
        wr_enb_0 = 1'b0;
    endtask

    // One cycle of optional write plus reads on both ports; checks instance b in C1, a in C2
    task automatic access(input string tag, input bit we, input logic [AW-1:0] wa, input logic [NSEG-1:0] wm,
                          input logic [WIDTH-1:0] wd, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_b);
        wr_enb_0 = we; wr_adr_0 = wa; wr_msk_0 = wm; wr_dat_0 = wd;
        rd_enb_0 = 1'b1; rd_adr_0 = a0;
        rd_enb_1 = 1'b1; rd_adr_1 = a1;
        @(negedge clk);
        idle();
        chk({tag, "_b0"}, dat_b0, exp_b);
        chk({tag, "_b1"}, dat_b1, exp_b);
        chk({tag, "_vb"}, WIDTH'({val_b0, val_b1}), WIDTH'(2'b11));
        @(negedge clk);
        chk({tag, "_a0"}, dat_a0, exp_a);
        chk({tag, "_a1"}, dat_a1, exp_a);
        chk({tag, "_va"}, WIDTH'({val_a0, val_a1}), WIDTH'(2'b11));
    endtask

    task automatic measure_busy(output int edges);
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (busy_a && edges < 200);
    endtask

    int               edges;
    logic [WIDTH-1:0] ones, mrg;

    initial begin
        ones = '1;
        mrg  = 72'hFFFFFF000000FFFFFF;
        reset = 1'b1;
        idle();
        rd_adr_0 = '0; rd_adr_1 = '0; wr_adr_0 = '0; wr_msk_0 = '0; wr_dat_0 = '0;
        repeat (2) @(negedge clk);

        // Requests held through the whole first sweep must be dropped
        rd_enb_0 = 1'b1; rd_adr_0 = 6'd7;
        wr_enb_0 = 1'b1; wr_adr_0 = 6'd7; wr_msk_0 = '1; wr_dat_0 = ones;
        reset = 1'b0;
        measure_busy(edges);
        chk("init_len", WIDTH'(edges), WIDTH'(64));
        idle();
        access("drop", 1'b0, '0, '0, '0, 6'd7, 6'd7, '0, '0);

        for (int a = 0; a < DEPTH; a++)
            wr1(AW'(a), '1, WIDTH'({$urandom(), $urandom(), $urandom()}));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        measure_busy(edges);
        chk("sweep_len", WIDTH'(edges), WIDTH'(64));
        access("zero_0_31", 1'b0, '0, '0, '0, 6'd0, 6'd31, '0, '0);
        access("zero_63", 1'b0, '0, '0, '0, 6'd63, 6'd63, '0, '0);

        wr1(6'd5, '1, 72'h123456789ABCDEF012);
        rd_enb_0 = 1'b1; rd_adr_0 = 6'd5;
        @(negedge clk);
        idle();
        chk("lat_c1_va0", WIDTH'(val_a0), '0);
        chk("lat_c1_da0", dat_a0, '0);
        chk("lat_c1_db0", dat_b0, 72'h123456789ABCDEF012);
        @(negedge clk);
        chk("lat_c2_va0", WIDTH'(val_a0), WIDTH'(1));
        chk("lat_c2_da0", dat_a0, 72'h123456789ABCDEF012);

        wr1(6'd9, '1, ones);
        access("fwd", 1'b1, 6'd9, 3'b010, '0, 6'd9, 6'd9, mrg, ones);
        access("fwd_after", 1'b0, '0, '0, '0, 6'd9, 6'd9, mrg, mrg);

        wr1(6'd3, 3'b111, {9{8'hAA}});
        wr1(6'd3, 3'b101, {9{8'h55}});
        access("mask", 1'b0, '0, '0, '0, 6'd3, 6'd3, 72'h555555AAAAAA555555, 72'h555555AAAAAA555555);

        // Reset lands while a read is in flight in the latched instance
        rd_enb_0 = 1'b1; rd_adr_0 = 6'd5;
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_va0", WIDTH'(val_a0), '0);
        chk("rst_vb0", WIDTH'(val_b0), '0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        measure_busy(edges);
        chk("restart_len", WIDTH'(edges), WIDTH'(64));

        for (int i = 0; i < 3000; i++) begin
            reset    = (i >= 1500 && i < 1502);
            rd_enb_0 = ($urandom_range(0, 9) < 7);
            rd_enb_1 = ($urandom_range(0, 9) < 7);
            wr_enb_0 = ($urandom_range(0, 9) < 6);
            rd_adr_0 = AW'($urandom_range(0, 7));
            rd_adr_1 = AW'($urandom_range(0, 7));
            wr_adr_0 = AW'($urandom_range(0, 7));
            wr_msk_0 = NSEG'($urandom_range(0, 7));
            wr_dat_0 = WIDTH'({$urandom(), $urandom(), $urandom()});
            @(negedge clk);
        end
        reset = 1'b0;
        idle();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
